// File: rtl/issue_wf_arbiter.sv
// Issue-stage wavefront arbiter: qualifies tracker valid bits with readiness,
// stall, flush and in-flight masking, then grants one wavefront per cycle round-robin.
module issue_wf_arbiter #(
   parameter int NUM_WF = 40,
   parameter int WFID_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_WF-1:0] valid_entry_in,
   input  logic [NUM_WF-1:0] wf_ready,
   input  logic              fu_stall,
   input  logic              flush_en,
   input  logic [WFID_W-1:0] flush_wfid,
   output logic              issued_valid,
   output logic [WFID_W-1:0] issued_wfid,
   output logic [WFID_W-1:0] rr_ptr
);

   localparam logic [WFID_W-1:0] LAST_WF  = WFID_W'(NUM_WF - 1);
   localparam logic [WFID_W:0]   NUM_WF_W = (WFID_W + 1)'(NUM_WF);

   logic              issued_valid_q, issued_valid_d;
   logic [WFID_W-1:0] issued_wfid_q, issued_wfid_d;
   logic [WFID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [NUM_WF-1:0] flush_vec_s;
   logic [NUM_WF-1:0] inflight_s;
   logic [NUM_WF-1:0] cand_s;
   logic              win_found_s;
   logic [WFID_W-1:0] win_idx_s;

   // One-hot decode of the flushed wavefront.
   always_comb begin
      flush_vec_s = '0;
      if (flush_en && (flush_wfid <= LAST_WF)) begin
         flush_vec_s[flush_wfid] = 1'b1;
      end else begin
         flush_vec_s = '0;
      end
   end

   // The wf on issued_* is still set in the tracker this cycle; mask it to avoid double issue.
   always_comb begin
      inflight_s = '0;
      if (issued_valid_q && (issued_wfid_q <= LAST_WF)) begin
         inflight_s[issued_wfid_q] = 1'b1;
      end else begin
         inflight_s = '0;
      end
   end

   // Qualified candidate vector.
   always_comb begin
      cand_s = valid_entry_in & wf_ready & ~inflight_s & ~flush_vec_s
             & {NUM_WF{~fu_stall}};
   end

   // Round-robin scan: first candidate at or above rr_ptr, wrapping at NUM_WF.
   always_comb begin : rr_scan
      logic [WFID_W:0]   sum_v;
      logic [WFID_W-1:0] idx_v;
      logic              hit_v;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      sum_v       = '0;
      idx_v       = '0;
      hit_v       = 1'b0;
      for (int i = 0; i < NUM_WF; i++) begin
         sum_v       = {1'b0, rr_ptr_q} + (WFID_W + 1)'(i);
         idx_v       = (sum_v >= NUM_WF_W) ? WFID_W'(sum_v - NUM_WF_W)
                                           : sum_v[WFID_W-1:0];
         hit_v       = cand_s[idx_v] & ~win_found_s;
         win_idx_s   = hit_v ? idx_v : win_idx_s;
         win_found_s = win_found_s | hit_v;
      end
   end

   // Next-state for the issue registers and the priority pointer.
   always_comb begin
      issued_valid_d = 1'b0;
      issued_wfid_d  = issued_wfid_q;
      rr_ptr_d       = rr_ptr_q;
      if (win_found_s) begin
         issued_valid_d = 1'b1;
         issued_wfid_d  = win_idx_s;
         rr_ptr_d       = (win_idx_s == LAST_WF) ? '0 : (win_idx_s + WFID_W'(1));
      end else begin
         issued_valid_d = 1'b0;
         issued_wfid_d  = issued_wfid_q;
         rr_ptr_d       = rr_ptr_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_valid_q <= 1'b0;
         issued_wfid_q  <= '0;
         rr_ptr_q       <= '0;
      end else begin
         issued_valid_q <= issued_valid_d;
         issued_wfid_q  <= issued_wfid_d;
         rr_ptr_q       <= rr_ptr_d;
      end
   end

   assign issued_valid = issued_valid_q;
   assign issued_wfid  = issued_wfid_q;
   assign rr_ptr       = rr_ptr_q;

endmodule

// File: doc/issue_wf_arbiter.md
Name: issue_wf_arbiter

Overview:
- Issue-stage selector that consumes the per-wavefront valid vector produced by the valid-entry tracker.
- Qualifies that vector with scoreboard readiness and functional-unit availability, then picks one wavefront per cycle using a rotating (round-robin) priority.
- Registers the winner as issued_valid/issued_wfid. That pair feeds back to the valid-entry tracker, which clears the entry, and goes forward to operand fetch.

Parameters:
- NUM_WF, 40, number of wavefront slots per CU (equals WF_PER_CU).
- WFID_W, 6, wavefront id width (equals WF_ID_LENGTH).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- valid_entry_in  input  NUM_WF  per-wf "instruction buffered and issuable" bits from the valid-entry tracker.
- wf_ready  input  NUM_WF  per-wf scoreboard-clear bits (operands and dependencies ready).
- fu_stall  input  1  downstream unit cannot accept an issue this cycle.
- flush_en  input  1  branch-taken flush valid.
- flush_wfid  input  WFID_W  wavefront being flushed.
- issued_valid  output  1  registered issue strobe.
- issued_wfid  output  WFID_W  registered id of the issued wavefront.
- rr_ptr  output  WFID_W  current highest-priority slot (debug/verification visibility).

Behaviour:
- Reset: issued_valid=0, issued_wfid=0, rr_ptr=0, inflight_mask=0. Reset wins over all other inputs in the same cycle, including mid-flush and mid-issue.
- Candidate vector (combinational): cand = valid_entry_in & wf_ready & ~inflight_mask & ~flush_vec & ~(fu_stall ? all-ones : 0).
  - flush_vec is the one-hot decode of flush_wfid, gated by flush_en.
- inflight_mask exists because the tracker clears its entry one cycle after seeing issued_valid. It prevents double issue.
  - inflight_mask = one-hot(issued_wfid) while issued_valid=1, else 0.
  - Effect: the wf currently presented on issued_* is never a candidate in the same cycle.
- Selection: the first set bit of cand, scanning upward from rr_ptr and wrapping from NUM_WF-1 to 0.
  - If rr_ptr itself is set in cand, rr_ptr wins.
  - Scan length is exactly NUM_WF slots. Slots >= NUM_WF never exist.
- Latency: one cycle. A candidate selected in cycle t appears on issued_valid/issued_wfid in cycle t+1 and is held for exactly one cycle.
  - Back-to-back issue of different wavefronts on consecutive cycles is allowed.
- Registered outputs at each edge:
  - If cand != 0: issued_valid<=1, issued_wfid<=winner, rr_ptr<=(winner==NUM_WF-1) ? 0 : winner+1.
  - If cand == 0: issued_valid<=0, issued_wfid holds its previous value, rr_ptr holds.
- rr_ptr arithmetic is modulo NUM_WF and is never allowed to reach NUM_WF. It advances only on a grant, never on a stall.
- fu_stall=1: no grant that cycle. issued_valid<=0 and rr_ptr holds. Valid entries are not consumed.
- Flush:
  - The flushed wf is excluded from selection in the same cycle.
  - If flush_wfid equals the wf currently on issued_* with issued_valid=1, that issue is not cancelled. Cancelling is the tracker/downstream's job. The arbiter only guarantees no new grant to that wf this cycle.
- Simultaneous events:
  - Flush plus stall: no grant.
  - Flush of the wf at rr_ptr: the scan continues to the next candidate.
  - All NUM_WF candidates set: rr_ptr wins.
- Output encoding: issued_wfid is WFID_W wide, with zero upper bits beyond the NUM_WF range.
- Fairness: with a persistently set candidate set of size k, every member is granted within k consecutive grant cycles.

Test Plan:
- Reset then single candidate: rst=1 for 2 cycles, then valid_entry_in=wf_ready=bit 5 (valid drops the cycle after issue, modelling the tracker) -> issued_valid=1, issued_wfid=5 exactly one cycle later; rr_ptr=6; no re-issue of 5 on the following cycle even though valid_entry_in[5] is still 1 in that cycle.
- Round-robin wrap: valid/ready held at bits {0,3,39} with issue never clearing them, rr_ptr=0 -> issue order 0,3,39,0,3 on consecutive alternate-free cycles (inflight masking means 0 is skipped only in the cycle it is presented); rr_ptr passes 1,4,0,1.
- Stall: candidates {2,7}, fu_stall=1 for 3 cycles -> issued_valid=0 throughout and rr_ptr unchanged; first cycle after deassert -> grant 2 (if rr_ptr<=2).
- Flush collision: candidates {10,11}, rr_ptr=10, flush_en=1 with flush_wfid=10 -> grant 11, rr_ptr=12; with the flush removed next cycle -> grant 10 after wrap.
- Readiness gating: valid_entry_in all ones, wf_ready=0 -> no issue for 20 cycles; then wf_ready[39]=1 -> issued_wfid=39, rr_ptr=0.
- Reset mid-issue: assert rst in the same cycle as a grant -> next cycle issued_valid=0, rr_ptr=0, inflight_mask cleared; the wf is eligible again after reset deasserts.
